// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op and state encodings for the iterative multiply/divide unit
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - request/result bundle between execute stage and the multiply/divide unit
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             ack;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, a, b, cancel, ack,
        input  busy, result_valid, hi, lo, div_zero
    );

    modport slave (
        input  start, op, a, b, cancel, ack,
        output busy, result_valid, hi, lo, div_zero
    );
endinterface

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] part_i,
    input  logic [WIDTH-1:0]   mag_i,
    input  logic               bit_i,
    output logic [2*WIDTH-1:0] part_o,
    output logic               q_o
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {part_i[WIDTH-1:0], bit_i};
        diff    = {1'b0, shifted} - {2'b00, mag_i};
        part_o  = '0;
        q_o     = 1'b0;
        if (is_div_i) begin
            // Borrow out of the trial subtraction means the divisor did not fit.
            q_o              = ~diff[WIDTH+1];
            part_o[WIDTH:0]  = diff[WIDTH+1] ? shifted : diff[WIDTH:0];
        end else begin
            part_o = (part_i << 1) + (bit_i ? {{WIDTH{1'b0}}, mag_i} : {(2*WIDTH){1'b0}});
        end
    end
endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative signed/unsigned multiply and divide producing {hi, lo}
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic      clk,
    input  logic      rst,
    mdu_iter_if.slave bus
);
    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   walk_q, walk_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dz_q, dz_d;

    mdu_op_e            in_op;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] step_part, prod_fix;
    logic               step_q;
    logic [WIDTH-1:0]   quo_next, quo_fix, rem_fix;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (div_q),
        .part_i   (acc_q),
        .mag_i    (mag_q),
        .bit_i    (walk_q[WIDTH-1]),
        .part_o   (step_part),
        .q_o      (step_q)
    );

    // Operand bits are walked MSB first; a zero divisor naturally yields an all-ones quotient.
    assign quo_next = {quo_q[WIDTH-2:0], step_q};
    assign prod_fix = neg_q ? -step_part : step_part;
    assign quo_fix  = bzero_q ? {WIDTH{1'b1}} : (neg_q ? -quo_next : quo_next);
    assign rem_fix  = rem_neg_q ? -step_part[WIDTH-1:0] : step_part[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        bzero_d   = bzero_q;
        walk_d    = walk_q;
        mag_d     = mag_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
        in_op     = mdu_op_e'(bus.op);
        a_neg     = op_is_signed(in_op) & bus.a[WIDTH-1];
        b_neg     = op_is_signed(in_op) & bus.b[WIDTH-1];
        mag_a     = a_neg ? -bus.a : bus.a;
        mag_b     = b_neg ? -bus.b : bus.b;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    state_d   = S_CALC;
                    cnt_d     = '0;
                    div_d     = op_is_div(in_op);
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    bzero_d   = (bus.b == '0);
                    walk_d    = op_is_div(in_op) ? mag_a : mag_b;
                    mag_d     = op_is_div(in_op) ? mag_b : mag_a;
                    acc_d     = '0;
                    quo_d     = '0;
                end
            end
            S_CALC: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d  = step_part;
                    quo_d  = quo_next;
                    walk_d = {walk_q[WIDTH-2:0], 1'b0};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_DONE;
                        if (div_q) begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                            dz_d = bzero_q;
                        end else begin
                            hi_d = prod_fix[2*WIDTH-1:WIDTH];
                            lo_d = prod_fix[WIDTH-1:0];
                            dz_d = 1'b0;
                        end
                    end
                end
            end
            S_DONE: begin
                if (bus.cancel || bus.ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            bzero_q   <= 1'b0;
            walk_q    <= '0;
            mag_q     <= '0;
            acc_q     <= '0;
            quo_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            bzero_q   <= bzero_d;
            walk_q    <= walk_d;
            mag_q     <= mag_d;
            acc_q     <= acc_d;
            quo_q     <= quo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.result_valid = (state_q == S_DONE);
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign bus.div_zero     = dz_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - randomized scoreboard bench for mdu_iter at WIDTH 32 and 8
module tb_mdu_iter;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(32)) bus32 ();
    mdu_iter_if #(.WIDTH(8))  bus8 ();

    mdu_iter #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    mdu_iter #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          t;
    } exp_t;

    typedef struct packed {
        logic        busy;
        logic        valid;
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } st_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic pv32 = 1'b0;
    logic pv8 = 1'b0;
    st_t  s0, snap0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic on sign-extended or zero-extended operands.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input int w, input int t);
        exp_t   e;
        longint mask, ua, ub, sa, sb, p, q, r;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = ua[w-1] ? ua - (longint'(1) << w) : ua;
        sb   = ub[w-1] ? ub - (longint'(1) << w) : ub;
        e.t  = t;
        e.dz = 1'b0;
        if (op[1] == 1'b0) begin
            p    = (op[0] == 1'b0) ? sa * sb : ua * ub;
            e.hi = 32'((p >> w) & mask);
            e.lo = 32'(p & mask);
        end else begin
            if (ub == 0) begin
                q = mask; r = ua; e.dz = 1'b1;
            end else if (op[0] == 1'b0) begin
                q = sa / sb; r = sa % sb;
            end else begin
                q = ua / ub; r = ua % ub;
            end
            e.lo = 32'(q & mask);
            e.hi = 32'(r & mask);
        end
        return e;
    endfunction

    function automatic st_t stat(input bit w8);
        st_t s;
        if (w8) begin
            s.busy = bus8.busy; s.valid = bus8.result_valid; s.dz = bus8.div_zero;
            s.hi = 32'(bus8.hi); s.lo = 32'(bus8.lo);
        end else begin
            s.busy = bus32.busy; s.valid = bus32.result_valid; s.dz = bus32.div_zero;
            s.hi = bus32.hi; s.lo = bus32.lo;
        end
        return s;
    endfunction

    task automatic drive(input bit w8, input logic st, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            bus8.start = st; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0];
        end else begin
            bus32.start = st; bus32.op = op; bus32.a = a; bus32.b = b;
        end
    endtask

    task automatic set_ack(input bit w8, input logic v);
        if (w8) bus8.ack = v; else bus32.ack = v;
    endtask

    always @(negedge clk) begin
        if (rst) pv32 = 1'b0;
        else begin
            if (bus32.result_valid && !pv32) begin
                if (q32.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w32_unexpected_valid: got valid expected none (cycle %0d)", cyc);
                end else begin
                    e32 = q32.pop_front();
                    chk("w32_hi", bus32.hi, e32.hi);
                    chk("w32_lo", bus32.lo, e32.lo);
                    chk("w32_div_zero", bus32.div_zero, e32.dz);
                    chk("w32_latency", cyc - e32.t, 32);
                end
            end
            pv32 = bus32.result_valid;
        end
    end

    always @(negedge clk) begin
        if (rst) pv8 = 1'b0;
        else begin
            if (bus8.result_valid && !pv8) begin
                if (q8.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w8_unexpected_valid: got valid expected none (cycle %0d)", cyc);
                end else begin
                    e8 = q8.pop_front();
                    chk("w8_hi", 32'(bus8.hi), e8.hi);
                    chk("w8_lo", 32'(bus8.lo), e8.lo);
                    chk("w8_div_zero", bus8.div_zero, e8.dz);
                    chk("w8_latency", cyc - e8.t, 8);
                end
            end
            pv8 = bus8.result_valid;
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run(input bit w8, input logic [1:0] op, input logic [31:0] a_in,
                       input logic [31:0] b_in, input int hold, input bit noise);
        logic [31:0] m;
        logic [31:0] a, b;
        exp_t        e;
        st_t         s, snap;
        int          n;
        m = w8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
        a = a_in & m;
        b = b_in & m;
        e = model(op, a, b, w8 ? 8 : 32, cyc + 1);
        if (w8) q8.push_back(e); else q32.push_back(e);
        drive(w8, 1'b1, op, a, b);
        @(negedge clk);
        drive(w8, 1'b0, op, a, b);
        s = stat(w8);
        chk("busy_in_calc", s.busy, 1);
        n = 0;
        while (!stat(w8).valid && n < 100) begin
            if (noise) drive(w8, 1'($urandom % 2), 2'($urandom), $urandom, $urandom);
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL timeout: result_valid not seen within 100 cycles (cycle %0d)", cyc);
        end
        snap = stat(w8);
        for (int i = 0; i < hold; i++) begin
            drive(w8, noise ? 1'($urandom % 2) : 1'b0, 2'($urandom), $urandom, $urandom);
            @(negedge clk);
            s = stat(w8);
            chk("hold_valid", s.valid, 1);
            chk("hold_busy", s.busy, 1);
            chk("hold_hi", s.hi, snap.hi);
            chk("hold_lo", s.lo, snap.lo);
        end
        drive(w8, 1'b0, op, a, b);
        set_ack(w8, 1'b1);
        @(negedge clk);
        set_ack(w8, 1'b0);
        s = stat(w8);
        chk("idle_after_ack_busy", s.busy, 0);
        chk("idle_after_ack_valid", s.valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        bus32.cancel = 1'b0; bus32.ack = 1'b0; bus8.cancel = 1'b0; bus8.ack = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            s0 = stat(k[0]);
            chk("reset_busy", s0.busy, 0);
            chk("reset_valid", s0.valid, 0);
            chk("reset_hilo", {s0.hi, s0.lo}, 0);
            chk("reset_div_zero", s0.dz, 0);
        end
        rst = 1'b0;
        @(negedge clk);

        run(1'b0, MDU_DIVU, 32'd100, 32'd7, 0, 1'b0);
        run(1'b0, MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run(1'b0, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run(1'b0, MDU_MULT, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
        run(1'b0, MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
        run(1'b0, MDU_DIVU, 32'd5, 32'd0, 0, 1'b0);
        run(1'b0, MDU_MULTU, 32'd3, 32'd4, 0, 1'b0);

        // Cancel while the counter is at 10, then restart on the very next cycle.
        snap0 = stat(1'b0);
        drive(1'b0, 1'b1, MDU_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        drive(1'b0, 1'b0, MDU_DIVU, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        bus32.cancel = 1'b1;
        @(negedge clk);
        bus32.cancel = 1'b0;
        s0 = stat(1'b0);
        chk("cancel_busy", s0.busy, 0);
        chk("cancel_valid", s0.valid, 0);
        chk("cancel_hi_kept", s0.hi, 32'd12 == snap0.lo ? 32'd0 : 32'hDEAD);
        chk("cancel_lo_kept", s0.lo, 32'd12);
        run(1'b0, MDU_DIVU, 32'd100, 32'd7, 0, 1'b0);

        drive(1'b0, 1'b1, MDU_MULTU, 32'd9, 32'd9);
        bus32.cancel = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b0, MDU_MULTU, 32'd9, 32'd9);
        bus32.cancel = 1'b0;
        chk("start_cancel_idle_busy", stat(1'b0).busy, 0);
        repeat (4) @(negedge clk);
        chk("start_cancel_idle_valid", stat(1'b0).valid, 0);

        run(1'b0, MDU_DIV, 32'hFFFF_FF9C, 32'd7, 5, 1'b1);

        run(1'b0, MDU_DIVU, 32'd5, 32'd0, 0, 1'b0);
        drive(1'b0, 1'b1, MDU_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        drive(1'b0, 1'b0, MDU_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        s0 = stat(1'b0);
        chk("midcalc_reset_busy", s0.busy, 0);
        chk("midcalc_reset_valid", s0.valid, 0);
        chk("midcalc_reset_hilo", {s0.hi, s0.lo}, 0);
        chk("midcalc_reset_div_zero", s0.dz, 0);
        rst = 1'b0;
        @(negedge clk);

        run(1'b1, MDU_DIV, 32'h80, 32'd3, 0, 1'b0);
        run(1'b1, MDU_DIV, 32'h80, 32'hFF, 0, 1'b0);
        run(1'b1, MDU_DIVU, 32'hF3, 32'd0, 2, 1'b1);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom % 8)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'd1;
                3: b = {28'd0, 4'($urandom)};
                default: ;
            endcase
            run(1'b0, op, a, b, int'($urandom % 3), 1'($urandom % 2));
        end
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom % 6)
                0: b = 32'd0;
                1: begin a = 32'h80; b = 32'hFF; end
                default: ;
            endcase
            run(1'b1, op, a, b, int'($urandom % 3), 1'($urandom % 2));
        end

        repeat (3) @(negedge clk);
        chk("w32_scoreboard_drained", q32.size(), 0);
        chk("w8_scoreboard_drained", q8.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
